// File: rtl/com_data_loader.sv
// rtl/com_data_loader.sv - host->processor link receiver that streams words into the shared data memory
module com_data_loader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] com_data_in,
    input  logic              data_write_start,
    input  logic              data_write_done,
    input  logic              load_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              load_done,
    output logic              overflow,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_DONE  = 2'b10,
        ST_ERROR = 2'b11
    } state_e;

    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   MAX_WC = (ADDR_W+1)'(MAX_WORDS);

    state_e             state_q, state_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]    word_count_q, word_count_d;
    logic               load_done_q, load_done_d;
    logic               overflow_q, overflow_d;
    // Final word has been sampled; its write is on the bus this cycle.
    logic               last_q, last_d;
    logic               sample;

    always_comb begin
        state_d      = state_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
        load_done_d  = load_done_q;
        overflow_d   = overflow_q;
        last_d       = last_q;
        sample       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_write_start) begin
                    sample  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_q) begin
                    state_d     = ST_DONE;
                    load_done_d = 1'b1;
                    last_d      = 1'b0;
                end else if (data_write_start || data_write_done) begin
                    sample = 1'b1;
                end
            end
            ST_DONE: begin
                if (load_ack) begin
                    state_d      = ST_IDLE;
                    load_done_d  = 1'b0;
                    word_count_d = '0;
                    mem_addr_d   = BASE;
                end
            end
            default: ;
        endcase

        // The sampled word becomes the registered write presented on the next cycle.
        if (sample) begin
            if (word_count_q == MAX_WC) begin
                overflow_d = 1'b1;
                state_d    = ST_ERROR;
            end else begin
                mem_we_d     = 1'b1;
                mem_addr_d   = BASE + word_count_q[ADDR_W-1:0];
                mem_wdata_d  = com_data_in;
                word_count_d = word_count_q + 1'b1;
                if (data_write_done) begin
                    last_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= BASE;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            word_count_q <= word_count_d;
            load_done_q  <= load_done_d;
            overflow_q   <= overflow_d;
            last_q       <= last_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign load_done  = load_done_q;
    assign overflow   = overflow_q;
    assign state      = state_q;

endmodule

// File: tb/tb_com_data_loader.sv
// tb/tb_com_data_loader.sv - directed self-checking bench for com_data_loader
module tb_com_data_loader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rstn;
    logic [DATA_W-1:0] com_data_in;
    logic              data_write_start;
    logic              data_write_done;
    logic              load_ack;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              load_done;
    logic              overflow;
    logic [1:0]        state;

    int n_vec  = 0;
    int n_miss = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [DATA_W-1:0] wd[$];

    com_data_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(0), .MAX_WORDS(4)
    ) dut (
        .clk(clk), .rstn(rstn), .com_data_in(com_data_in),
        .data_write_start(data_write_start), .data_write_done(data_write_done),
        .load_ack(load_ack), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .word_count(word_count), .load_done(load_done),
        .overflow(overflow), .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic d, input logic [DATA_W-1:0] w);
        data_write_start = s;
        data_write_done  = d;
        com_data_in      = w;
        step();
    endtask

    task automatic ack();
        load_ack = 1'b1;
        step();
        load_ack = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n,
                                input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                                input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3);
        logic [DATA_W-1:0] exp_w[4];
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
        expect_eq({tag, "_nwr"}, wa.size(), n);
        for (int i = 0; i < n && i < wa.size(); i++) begin
            expect_eq($sformatf("%s_addr%0d", tag, i), wa[i], i);
            expect_eq($sformatf("%s_data%0d", tag, i), wd[i], exp_w[i]);
        end
    endtask

    initial begin
        rstn = 1'b0;
        com_data_in = '0;
        data_write_start = 1'b0;
        data_write_done = 1'b0;
        load_ack = 1'b0;
        step();
        step();
        expect_eq("rst_state", state, 2'b00);
        expect_eq("rst_we", mem_we, 0);
        expect_eq("rst_addr", mem_addr, 0);
        expect_eq("rst_wdata", mem_wdata, 0);
        expect_eq("rst_wc", word_count, 0);
        expect_eq("rst_done", load_done, 0);
        expect_eq("rst_ovf", overflow, 0);
        rstn = 1'b1;
        step();

        // done without start in IDLE must not start an empty load
        drive(1'b0, 1'b1, 16'h00AA);
        drive(1'b0, 1'b0, 16'h0000);
        expect_eq("idle_done_state", state, 2'b00);
        expect_eq("idle_done_nwr", wa.size(), 0);

        // test 1: words 5,6,7
        wa.delete(); wd.delete();
        drive(1'b1, 1'b0, 16'd5);
        drive(1'b1, 1'b0, 16'd6);
        drive(1'b1, 1'b1, 16'd7);
        expect_eq("t1_lastwe", mem_we, 1);
        expect_eq("t1_lastaddr", mem_addr, 2);
        expect_eq("t1_done_early", load_done, 0);
        drive(1'b0, 1'b0, 16'd0);
        expect_eq("t1_state", state, 2'b10);
        expect_eq("t1_done", load_done, 1);
        expect_eq("t1_wc", word_count, 3);
        expect_eq("t1_we_off", mem_we, 0);
        check_writes("t1", 3, 16'd5, 16'd6, 16'd7, 16'd0);

        // test 6: input churn in DONE is ignored
        for (int i = 0; i < 10; i++) drive(i[0], 1'b0, 16'(16'h1234 + i * 16'h0111));
        data_write_start = 1'b0;
        expect_eq("t6_nwr", wa.size(), 3);
        expect_eq("t6_state", state, 2'b10);
        expect_eq("t6_wc", word_count, 3);

        // test 2: ack then second stream 9,8
        ack();
        expect_eq("t2_state", state, 2'b00);
        expect_eq("t2_wc", word_count, 0);
        expect_eq("t2_done", load_done, 0);
        expect_eq("t2_addr", mem_addr, 0);
        wa.delete(); wd.delete();
        drive(1'b1, 1'b0, 16'd9);
        drive(1'b1, 1'b1, 16'd8);
        drive(1'b0, 1'b0, 16'd0);
        step();
        expect_eq("t2_state2", state, 2'b10);
        expect_eq("t2_wc2", word_count, 2);
        check_writes("t2", 2, 16'd9, 16'd8, 16'd0, 16'd0);
        ack();

        // test 3: start paused for two cycles
        wa.delete(); wd.delete();
        drive(1'b1, 1'b0, 16'd1);
        drive(1'b1, 1'b0, 16'd2);
        drive(1'b0, 1'b0, 16'd77);
        drive(1'b0, 1'b0, 16'd78);
        expect_eq("t3_gap_state", state, 2'b01);
        drive(1'b1, 1'b1, 16'd3);
        drive(1'b0, 1'b0, 16'd0);
        step();
        expect_eq("t3_state", state, 2'b10);
        expect_eq("t3_wc", word_count, 3);
        check_writes("t3", 3, 16'd1, 16'd2, 16'd3, 16'd0);
        ack();

        // test 4: five words into a four-word window
        wa.delete(); wd.delete();
        drive(1'b1, 1'b0, 16'd11);
        drive(1'b1, 1'b0, 16'd12);
        drive(1'b1, 1'b0, 16'd13);
        drive(1'b1, 1'b0, 16'd14);
        drive(1'b1, 1'b1, 16'd15);
        drive(1'b0, 1'b0, 16'd0);
        step();
        expect_eq("t4_ovf", overflow, 1);
        expect_eq("t4_state", state, 2'b11);
        expect_eq("t4_wc", word_count, 4);
        expect_eq("t4_addr", mem_addr, 3);
        check_writes("t4", 4, 16'd11, 16'd12, 16'd13, 16'd14);
        ack();
        drive(1'b1, 1'b1, 16'd99);
        data_write_start = 1'b0;
        data_write_done = 1'b0;
        expect_eq("t4_sticky_state", state, 2'b11);
        expect_eq("t4_sticky_nwr", wa.size(), 4);

        // test 5: reset pulse mid-load
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        step();
        wa.delete(); wd.delete();
        drive(1'b1, 1'b0, 16'd21);
        drive(1'b1, 1'b0, 16'd22);
        rstn = 1'b0;
        #1;
        expect_eq("t5_state", state, 2'b00);
        expect_eq("t5_we", mem_we, 0);
        expect_eq("t5_wc", word_count, 0);
        expect_eq("t5_addr", mem_addr, 0);
        expect_eq("t5_ovf", overflow, 0);
        step();
        expect_eq("t5_held_we", mem_we, 0);
        wa.delete(); wd.delete();
        rstn = 1'b1;
        drive(1'b1, 1'b1, 16'd31);
        drive(1'b0, 1'b0, 16'd0);
        step();
        expect_eq("t5_state2", state, 2'b10);
        expect_eq("t5_wc2", word_count, 1);
        check_writes("t5", 1, 16'd31, 16'd0, 16'd0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
